matrix_stream_packetiser: RTL and testbench

- Receiving end of the core's matrix output port. Consumes the one-cycle write strobes produced by the PicoRV32 system block: matrix data, end-of-row, end-of-matrix and destination position.
- Tags each element with its destination node and its (row, col) index, buffers the result in a FIFO and presents it as flits to the Hoplite router injection port.
- Absorbs the core's unthrottled bursts and reports overflow, because the core has no backpressure on this interface.

---
 rtl/matrix_stream_packetiser_pkg.sv | 20 ++
 rtl/matrix_stream_packetiser_fifo.sv | 74 +++++++
 rtl/matrix_stream_packetiser.sv | 104 ++++++++++
 tb/tb_matrix_stream_packetiser.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_stream_packetiser_pkg.sv
// Flit layout shared by the packetiser, the Hoplite router and the depacketiser.
// Fields are MSB first: {last, dest_x, dest_y, row, col, data}.
package matrix_stream_packetiser_pkg;

    localparam int FLIT_COORD_BITS = 4;
    localparam int FLIT_IDX_BITS   = 4;
    localparam int FLIT_DATA_BITS  = 32;
    localparam int FLIT_WIDTH      = 1 + 2*FLIT_COORD_BITS + 2*FLIT_IDX_BITS + FLIT_DATA_BITS;

    localparam int DATA_LSB   = 0;
    localparam int COL_LSB    = DATA_LSB + FLIT_DATA_BITS;
    localparam int ROW_LSB    = COL_LSB + FLIT_IDX_BITS;
    localparam int DEST_Y_LSB = ROW_LSB + FLIT_IDX_BITS;
    localparam int DEST_X_LSB = DEST_Y_LSB + FLIT_COORD_BITS;
    localparam int LAST_BIT   = DEST_X_LSB + FLIT_COORD_BITS;

    // Payload carried by the end-of-matrix marker flit.
    localparam logic [FLIT_DATA_BITS-1:0] END_MARKER_DATA = '0;

endpackage

// File: rtl/matrix_stream_packetiser_fifo.sv
// flit_fifo: synchronous first-word-fall-through FIFO with occupancy count.
// A pop makes room for a push in the same cycle, even when full.
module flit_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_next;
    logic             almost_full_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        count_next = count_q;
        if (push_ok && !pop_ok) begin
            count_next = count_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q       <= count_next;
            almost_full_q <= (count_next >= CW'(DEPTH - 2));
        end
    end

    // Storage needs no reset: an entry is only visible once it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata       = empty ? '0 : mem[rd_ptr];
    assign count       = count_q;
    assign almost_full = almost_full_q;

endmodule

// File: rtl/matrix_stream_packetiser.sv
// Tags the core's matrix write strobes with destination and (row, col) and
// queues them as flits for the Hoplite router injection port.
module matrix_stream_packetiser
    import matrix_stream_packetiser_pkg::*;
#(
    parameter int COORD_BITS = FLIT_COORD_BITS,
    parameter int MATRIX_DIM = 8,
    parameter int IDX_BITS   = FLIT_IDX_BITS,
    parameter int FIFO_DEPTH = 16,
    parameter int FLIT_BITS  = 1 + 2*COORD_BITS + 2*IDX_BITS + FLIT_DATA_BITS
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [FLIT_DATA_BITS-1:0]     in_matrix,
    input  logic                          in_matrix_en,
    input  logic                          in_matrix_end_row,
    input  logic                          in_matrix_end,
    input  logic [2*COORD_BITS-1:0]       in_position,
    input  logic                          in_position_en,
    output logic [FLIT_BITS-1:0]          flit_out,
    output logic                          flit_out_valid,
    input  logic                          flit_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          almost_full,
    output logic                          overflow
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(MATRIX_DIM - 1);

    logic [2*COORD_BITS-1:0] dest_q;
    logic [2*COORD_BITS-1:0] dest_eff;
    logic [IDX_BITS-1:0]     row_q;
    logic [IDX_BITS-1:0]     col_q;
    logic [FLIT_BITS-1:0]    push_flit;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    overflow_q;

    // Handshake: a flit transfers on a rising edge where flit_out_valid and
    // flit_out_ready are both high; while valid is high and ready is low the
    // flit and valid hold. Valid never depends on ready.
    assign flit_out_valid = !fifo_empty;
    assign pop            = flit_out_valid && flit_out_ready;

    // A position strobed alongside an element applies to that element.
    assign dest_eff = in_position_en ? in_position : dest_q;
    assign push     = in_matrix_en || in_matrix_end;

    assign push_flit = {in_matrix_end, dest_eff, row_q, col_q,
                        in_matrix_en ? in_matrix : END_MARKER_DATA};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dest_q <= '0;
        end else if (in_position_en) begin
            dest_q <= in_position;
        end
    end

    // End of matrix outranks end of row; counters advance even if the push drops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_q <= '0;
            col_q <= '0;
        end else if (in_matrix_end) begin
            row_q <= '0;
            col_q <= '0;
        end else if (in_matrix_end_row) begin
            col_q <= '0;
            row_q <= (row_q == LAST_IDX) ? '0 : row_q + IDX_BITS'(1);
        end else if (in_matrix_en) begin
            col_q <= (col_q == LAST_IDX) ? '0 : col_q + IDX_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;

    flit_fifo #(
        .WIDTH (FLIT_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push        (push),
        .wdata       (push_flit),
        .pop         (pop),
        .rdata       (flit_out),
        .count       (fifo_count),
        .almost_full (almost_full),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

endmodule

// File: tb/tb_matrix_stream_packetiser.sv
// Bench for matrix_stream_packetiser: directed scenarios plus random strobes,
// all checked against a queue-based reference model.
module tb_matrix_stream_packetiser;
    import matrix_stream_packetiser_pkg::*;

    localparam int DEPTH = 16;
    localparam int DIM   = 8;
    localparam int FW    = 49;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]   in_matrix = '0;
    logic          in_matrix_en = 1'b0;
    logic          in_matrix_end_row = 1'b0;
    logic          in_matrix_end = 1'b0;
    logic [7:0]    in_position = '0;
    logic          in_position_en = 1'b0;
    logic [FW-1:0] flit_out;
    logic          flit_out_valid;
    logic          flit_out_ready = 1'b0;
    logic [4:0]    fifo_count;
    logic          almost_full;
    logic          overflow;

    matrix_stream_packetiser dut (
        .clk               (clk),
        .resetn            (resetn),
        .in_matrix         (in_matrix),
        .in_matrix_en      (in_matrix_en),
        .in_matrix_end_row (in_matrix_end_row),
        .in_matrix_end     (in_matrix_end),
        .in_position       (in_position),
        .in_position_en    (in_position_en),
        .flit_out          (flit_out),
        .flit_out_valid    (flit_out_valid),
        .flit_out_ready    (flit_out_ready),
        .fifo_count        (fifo_count),
        .almost_full       (almost_full),
        .overflow          (overflow)
    );

    // ---------------- scoreboard / reference model ----------------
    logic [FW-1:0] exp_q[$];
    int            m_row;
    int            m_col;
    logic [7:0]    m_dest;
    logic          m_ovf;
    int            checks = 0;
    int            passed = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [FW-1:0] mk(input logic last, input logic [7:0] dest,
                                         input int row, input int col, input logic [31:0] d);
        logic [FW-1:0] f;
        f = '0;
        f[LAST_BIT]          = last;
        f[DEST_X_LSB +: 4]   = dest[7:4];
        f[DEST_Y_LSB +: 4]   = dest[3:0];
        f[ROW_LSB +: 4]      = row[3:0];
        f[COL_LSB +: 4]      = col[3:0];
        f[DATA_LSB +: 32]    = d;
        return f;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_row  = 0;
        m_col  = 0;
        m_dest = 8'h00;
        m_ovf  = 1'b0;
    endtask

    task automatic compare_outputs(input string tag);
        int n;
        n = exp_q.size();
        check_eq({tag, "_valid"}, 64'(flit_out_valid), 64'(n > 0));
        check_eq({tag, "_count"}, 64'(fifo_count), 64'(n));
        check_eq({tag, "_afull"}, 64'(almost_full), 64'(n >= DEPTH - 2));
        check_eq({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
        check_eq({tag, "_flit"}, 64'(flit_out), (n > 0) ? 64'(exp_q[0]) : 64'(0));
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drives one cycle of strobes, advances the model
    // across the rising edge, then compares at the next falling edge.
    task automatic cycle(input bit en, input bit er, input bit me, input bit pe,
                         input logic [7:0] pos, input logic [31:0] d, input bit rdy,
                         input string tag);
        logic          do_pop;
        logic [FW-1:0] f;
        in_matrix_en      = en;
        in_matrix_end_row = er;
        in_matrix_end     = me;
        in_position_en    = pe;
        in_position       = pos;
        in_matrix         = d;
        flit_out_ready    = rdy;

        do_pop = (exp_q.size() > 0) && rdy;
        if (pe) m_dest = pos;
        f = mk(me, m_dest, m_row, m_col, en ? d : 32'h0);
        if (do_pop) void'(exp_q.pop_front());
        if (en || me) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(f);
            else m_ovf = 1'b1;
        end
        if (me) begin
            m_row = 0;
            m_col = 0;
        end else if (er) begin
            m_col = 0;
            m_row = (m_row + 1) % DIM;
        end else if (en) begin
            m_col = (m_col + 1) % DIM;
        end

        @(posedge clk);
        @(negedge clk);
        in_matrix_en      = 1'b0;
        in_matrix_end_row = 1'b0;
        in_matrix_end     = 1'b0;
        in_position_en    = 1'b0;
        compare_outputs(tag);
    endtask

    task automatic elem(input logic [31:0] d, input bit rdy, input string tag);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, d, rdy, tag);
    endtask

    task automatic idle(input bit rdy, input string tag);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, rdy, tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        resetn = 1'b0;
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        compare_outputs(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_outputs("rst");
        resetn = 1'b1;
        @(negedge clk);

        // 1: position then two elements
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h21, 32'h0, 1'b1, "t1_pos");
        elem(32'hA, 1'b1, "t1_a");
        check_eq("t1_first", 64'(flit_out), 64'(mk(1'b0, 8'h21, 0, 0, 32'hA)));
        elem(32'hB, 1'b1, "t1_b");
        check_eq("t1_second", 64'(flit_out), 64'(mk(1'b0, 8'h21, 0, 1, 32'hB)));
        idle(1'b1, "t1_idle");

        // 2: 2x2 matrix
        do_reset("t2_rst");
        elem(32'd1, 1'b1, "t2_e1");
        check_eq("t2_00", 64'(flit_out), 64'(mk(1'b0, 8'h00, 0, 0, 32'd1)));
        elem(32'd2, 1'b1, "t2_e2");
        check_eq("t2_01", 64'(flit_out), 64'(mk(1'b0, 8'h00, 0, 1, 32'd2)));
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, "t2_er1");
        elem(32'd3, 1'b1, "t2_e3");
        check_eq("t2_10", 64'(flit_out), 64'(mk(1'b0, 8'h00, 1, 0, 32'd3)));
        elem(32'd4, 1'b1, "t2_e4");
        check_eq("t2_11", 64'(flit_out), 64'(mk(1'b0, 8'h00, 1, 1, 32'd4)));
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, "t2_er2");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b1, "t2_end");
        check_eq("t2_marker", 64'(flit_out), 64'(mk(1'b1, 8'h00, 2, 0, 32'h0)));
        idle(1'b1, "t2_idle");

        // 3: coincident strobes
        do_reset("t3_rst");
        elem(32'h9, 1'b1, "t3_pre");
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'h55, 1'b1, "t3_enend");
        check_eq("t3_last", 64'(flit_out), 64'(mk(1'b1, 8'h00, 0, 1, 32'h55)));
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h37, 32'h66, 1'b1, "t3_posen");
        check_eq("t3_newdest", 64'(flit_out), 64'(mk(1'b0, 8'h37, 0, 0, 32'h66)));
        idle(1'b1, "t3_idle");
        check_eq("t3_single", 64'(fifo_count), 64'(0));

        // 4: backpressure and overflow
        do_reset("t4_rst");
        for (int i = 0; i <= DEPTH; i++) elem(32'h100 + 32'(i), 1'b0, "t4_push");
        check_eq("t4_count", 64'(fifo_count), 64'(16));
        check_eq("t4_afull", 64'(almost_full), 64'(1));
        check_eq("t4_ovf", 64'(overflow), 64'(1));
        check_eq("t4_head", 64'(flit_out), 64'(mk(1'b0, 8'h00, 0, 0, 32'h100)));
        for (int i = 0; i < DEPTH; i++) begin
            check_eq("t4_drain", 64'(flit_out), 64'(mk(1'b0, 8'h00, 0, i % DIM, 32'h100 + 32'(i))));
            idle(1'b1, "t4_pop");
        end
        check_eq("t4_empty", 64'(flit_out_valid), 64'(0));

        // 5: full with simultaneous pop
        do_reset("t5_rst");
        for (int i = 0; i < DEPTH; i++) elem(32'h200 + 32'(i), 1'b0, "t5_fill");
        elem(32'h2FF, 1'b1, "t5_pushpop");
        check_eq("t5_count", 64'(fifo_count), 64'(16));
        check_eq("t5_ovf", 64'(overflow), 64'(0));

        // 6: asynchronous reset mid-stream
        do_reset("t6_rst");
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 32'h0, 1'b0, "t6_pos");
        for (int i = 0; i < 5; i++) elem(32'h300 + 32'(i), 1'b0, "t6_fill");
        #2;
        resetn = 1'b0;
        #1;
        check_eq("t6_async_valid", 64'(flit_out_valid), 64'(0));
        check_eq("t6_async_count", 64'(fifo_count), 64'(0));
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        elem(32'h77, 1'b0, "t6_after");
        check_eq("t6_tag", 64'(flit_out), 64'(mk(1'b0, 8'h00, 0, 0, 32'h77)));

        // Random strobes with phases of varying router backpressure
        do_reset("rnd_rst");
        for (int i = 0; i < 900; i++) begin
            int rdy_pct;
            rdy_pct = ((i / 100) % 3 == 0) ? 15 : (((i / 100) % 3 == 1) ? 60 : 95);
            cycle($urandom_range(0, 99) < 55,
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 10,
                  8'($urandom), $urandom,
                  $urandom_range(0, 99) < rdy_pct, "rnd");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
